bcd_game_timer: RTL and testbench

Parametrised BCD game timer that drives the time-left display digits and tells game control when the round is over. It generalises the fixed two-digit count-up counter with:
- configurable digit count, start value and count direction;
- a Speed input that is actually used;
- start/pause/reload control;
- a proper terminal state with expiry pulse.

It sits between the game FSM (Start/Pause/Load) and the per-digit hex decoders.

---
 rtl/bcd_game_timer.sv | 193 +++++++++++++++++++
 tb/tb_bcd_game_timer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_game_timer.sv
// BCD round timer with start/pause/reload control, expiry pulse and step tick.
// Optional low-time Warning output is built in when BCD_GAME_TIMER_WARNING_EN is defined.
module bcd_game_timer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int DIGITS          = 2,
    parameter int START_VALUE     = 60,
    parameter int COUNT_DOWN      = 1
`ifdef BCD_GAME_TIMER_WARNING_EN
    ,
    parameter int WARN_VALUE      = 10
`endif
) (
    input  logic                ClockIn,
    input  logic                ResetN,
    input  logic                Start,
    input  logic                Pause,
    input  logic                Load,
    input  logic [1:0]          Speed,
    output logic [4*DIGITS-1:0] Digits,
    output logic                Running,
    output logic                Done,
    output logic                Expired,
    output logic                Tick
`ifdef BCD_GAME_TIMER_WARNING_EN
    ,
    output logic                Warning
`endif
);

    localparam int PW = $clog2(CLOCK_FREQUENCY);
    localparam int BW = 4 * DIGITS;

    function automatic logic [BW-1:0] to_bcd(input int value);
        logic [BW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [BW-1:0] INIT_BCD   = (COUNT_DOWN != 0) ? to_bcd(START_VALUE) : '0;
    localparam logic [BW-1:0] TERM_BCD   = (COUNT_DOWN != 0) ? '0 : to_bcd(START_VALUE);
    localparam logic [3:0]    WRAP_DIGIT = (COUNT_DOWN != 0) ? 4'd0 : 4'd9;
    localparam logic [3:0]    WRAP_TO    = (COUNT_DOWN != 0) ? 4'd9 : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   digits_reg, digits_next;
    logic [PW-1:0]   prescaler_reg, prescaler_next;
    logic            tick_reg, tick_next;
    logic            expired_reg, expired_next;

    logic [PW-1:0]   reload_value;
    logic [BW-1:0]   stepped;
    logic [DIGITS-1:0] at_wrap;
    logic [DIGITS-1:0] ripple_in;

    // Speed is sampled only when the prescaler is (re)loaded.
    assign reload_value = PW'((CLOCK_FREQUENCY >> Speed) - 1);

    // A digit steps when every lower digit sits at its wrap value, so the
    // borrow/carry is a per-digit AND reduction rather than a ripple chain.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            assign cur         = digits_reg[4*gi +: 4];
            assign at_wrap[gi] = (cur == WRAP_DIGIT);
            if (gi == 0) begin : g_lsd
                assign ripple_in[gi] = 1'b1;
            end else begin : g_upper
                assign ripple_in[gi] = &at_wrap[gi-1:0];
            end
            assign stepped[4*gi +: 4] = !ripple_in[gi]      ? cur :
                                        at_wrap[gi]         ? WRAP_TO :
                                        (COUNT_DOWN != 0)   ? cur - 4'd1 :
                                                              cur + 4'd1;
        end
    endgenerate

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            state_reg     <= ST_IDLE;
            digits_reg    <= INIT_BCD;
            prescaler_reg <= '0;
            tick_reg      <= 1'b0;
            expired_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digits_reg    <= digits_next;
            prescaler_reg <= prescaler_next;
            tick_reg      <= tick_next;
            expired_reg   <= expired_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        digits_next    = digits_reg;
        prescaler_next = prescaler_reg;
        tick_next      = 1'b0;
        expired_next   = 1'b0;
        if (Load) begin
            state_next     = ST_IDLE;
            digits_next    = INIT_BCD;
            prescaler_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Start) begin
                        if (START_VALUE == 0) begin
                            state_next   = ST_DONE;
                            expired_next = 1'b1;
                        end else begin
                            state_next     = ST_RUN;
                            prescaler_next = reload_value;
                        end
                    end
                end
                ST_RUN: begin
                    // Pause beats a pending step; the zero prescaler is kept so
                    // the step fires on the first cycle after resuming.
                    if (Pause) begin
                        state_next = ST_PAUSED;
                    end else if (prescaler_reg == '0) begin
                        tick_next      = 1'b1;
                        digits_next    = stepped;
                        prescaler_next = reload_value;
                        if (stepped == TERM_BCD) begin
                            state_next     = ST_DONE;
                            expired_next   = 1'b1;
                            prescaler_next = '0;
                        end
                    end else begin
                        prescaler_next = prescaler_reg - PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (Start) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        Digits  = digits_reg;
        Running = (state_reg == ST_RUN);
        Done    = (state_reg == ST_DONE);
        Expired = expired_reg;
        Tick    = tick_reg;
    end

`ifdef BCD_GAME_TIMER_WARNING_EN
    logic warning_reg, warning_next;
    int   count_bin;
    int   remaining;

    // Warning follows the value being written into Digits this cycle.
    always_comb begin
        count_bin = 0;
        for (int i = 0; i < DIGITS; i++) begin
            count_bin = count_bin * 10 + int'(digits_next[4*(DIGITS-1-i) +: 4]);
        end
        remaining    = (COUNT_DOWN != 0) ? count_bin : (START_VALUE - count_bin);
        warning_next = ((state_next == ST_RUN) || (state_next == ST_PAUSED)) &&
                       (remaining <= WARN_VALUE);
    end

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            warning_reg <= 1'b0;
        end else begin
            warning_reg <= warning_next;
        end
    end

    assign Warning = warning_reg;
`endif

endmodule

// File: tb/tb_bcd_game_timer.sv
// Bench for bcd_game_timer: four configurations against an integer-count model,
// plus directed checks with hand-computed values.
module tb_bcd_game_timer;

    localparam int N  = 4;
    localparam int CF = 8;
    localparam int D_T  [N] = '{2, 2, 2, 1};
    localparam int SV_T [N] = '{12, 25, 0, 5};
    localparam int DN_T [N] = '{1, 0, 1, 1};
    localparam int WV_T [N] = '{10, 10, 10, 3};
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic           ClockIn = 1'b0;
    logic           ResetN  = 1'b1;
    logic [N-1:0]   ld = '0, ps = '0, sr = '0;
    logic [1:0]     spd [N];
    logic [N-1:0]   run_o, done_o, exp_o, tick_o;
`ifdef BCD_GAME_TIMER_WARNING_EN
    logic [N-1:0]   warn_o;
`endif
    logic [15:0]    dgx [N];
    int             checks   = 0;
    int             failures = 0;
    bit             cmp_en   = 1'b0;

    always #5 ClockIn = ~ClockIn;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            logic [4*D_T[gi]-1:0] d_loc;
            bcd_game_timer #(
                .CLOCK_FREQUENCY(CF),
                .DIGITS         (D_T[gi]),
                .START_VALUE    (SV_T[gi]),
                .COUNT_DOWN     (DN_T[gi])
`ifdef BCD_GAME_TIMER_WARNING_EN
                ,
                .WARN_VALUE     (WV_T[gi])
`endif
            ) u_dut (
                .ClockIn(ClockIn),
                .ResetN (ResetN),
                .Start  (sr[gi]),
                .Pause  (ps[gi]),
                .Load   (ld[gi]),
                .Speed  (spd[gi]),
                .Digits (d_loc),
                .Running(run_o[gi]),
                .Done   (done_o[gi]),
                .Expired(exp_o[gi]),
                .Tick   (tick_o[gi])
`ifdef BCD_GAME_TIMER_WARNING_EN
                ,
                .Warning(warn_o[gi])
`endif
            );
            assign dgx[gi] = 16'(d_loc);
        end
    endgenerate

    // Model: plain integer count and prescaler per timer.
    typedef struct {
        int st;
        int cnt;
        int pre;
        bit tick;
        bit exp;
        bit warn;
    } mdl_t;

    mdl_t m [N];

    function automatic mdl_t mdl_reset(int i);
        mdl_t r;
        r.st   = S_IDLE;
        r.cnt  = (DN_T[i] != 0) ? SV_T[i] : 0;
        r.pre  = 0;
        r.tick = 1'b0;
        r.exp  = 1'b0;
        r.warn = 1'b0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t c, int i);
        mdl_t n;
        int   per;
        int   rem;
        n      = c;
        per    = CF >> spd[i];
        n.tick = 1'b0;
        n.exp  = 1'b0;
        if (ld[i]) begin
            n = mdl_reset(i);
        end else begin
            case (c.st)
                S_IDLE: if (sr[i]) begin
                    if (SV_T[i] == 0) begin
                        n.st  = S_DONE;
                        n.exp = 1'b1;
                    end else begin
                        n.st  = S_RUN;
                        n.pre = per - 1;
                    end
                end
                S_RUN: begin
                    if (ps[i]) begin
                        n.st = S_PAUSE;
                    end else if (c.pre == 0) begin
                        n.tick = 1'b1;
                        n.cnt  = (DN_T[i] != 0) ? c.cnt - 1 : c.cnt + 1;
                        n.pre  = per - 1;
                        if (n.cnt == ((DN_T[i] != 0) ? 0 : SV_T[i])) begin
                            n.st  = S_DONE;
                            n.exp = 1'b1;
                        end
                    end else begin
                        n.pre = c.pre - 1;
                    end
                end
                S_PAUSE: if (sr[i]) n.st = S_RUN;
                default: ;
            endcase
        end
        rem    = (DN_T[i] != 0) ? n.cnt : SV_T[i] - n.cnt;
        n.warn = ((n.st == S_RUN) || (n.st == S_PAUSE)) && (rem <= WV_T[i]);
        return n;
    endfunction

    always @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < N; i++) m[i] <= mdl_reset(i);
        end else begin
            for (int i = 0; i < N; i++) m[i] <= mdl_step(m[i], i);
        end
    end

    function automatic logic [15:0] tb_bcd(int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(logic [15:0] d);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (d[4*k +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ClockIn) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("u%0d_digits", i),  dgx[i],    tb_bcd(m[i].cnt));
                chk($sformatf("u%0d_bcdvalid", i), bcd_ok(dgx[i]), 1);
                chk($sformatf("u%0d_running", i), run_o[i],  (m[i].st == S_RUN));
                chk($sformatf("u%0d_done", i),    done_o[i], (m[i].st == S_DONE));
                chk($sformatf("u%0d_expired", i), exp_o[i],  m[i].exp);
                chk($sformatf("u%0d_tick", i),    tick_o[i], m[i].tick);
`ifdef BCD_GAME_TIMER_WARNING_EN
                chk($sformatf("u%0d_warning", i), warn_o[i], m[i].warn);
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ClockIn);
    endtask

    task automatic note(input string s);
        $display("TXN t=%0t %s", $time, s);
    endtask

    task automatic pulse_start(input int i);
        sr[i] = 1'b1;
        cyc(1);
        sr[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) spd[i] = 2'd0;
        #1 ResetN = 1'b0;
        #1 cmp_en = 1'b1;
        cyc(1);
        note("reset state");
        chk("rst_u0_digits", dgx[0], 16'h0012);
        chk("rst_u1_digits", dgx[1], 16'h0000);
        chk("rst_u3_digits", dgx[3], 16'h0005);
        chk("rst_flags", {run_o, done_o, exp_o, tick_o}, 16'h0000);
        ResetN = 1'b1;
        cyc(1);

        note("u0 start, speed 0");
        pulse_start(0);
        cyc(7);
        chk("t1_pre_tick", tick_o[0], 1'b0);
        cyc(1);
        chk("t1_first_tick", tick_o[0], 1'b1);
        chk("t1_first_digits", dgx[0], 16'h0011);
        cyc(8);
        chk("t1_digits_10", dgx[0], 16'h0010);
        cyc(8);
        chk("t1_borrow_09", dgx[0], 16'h0009);
        cyc(72);
        note("u0 expiry");
        chk("t1_expired", exp_o[0], 1'b1);
        chk("t1_done", done_o[0], 1'b1);
        chk("t1_zero", dgx[0], 16'h0000);
        cyc(1);
        chk("t1_expired_once", exp_o[0], 1'b0);
        chk("t1_done_hold", done_o[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            chk("t1_no_tick_done", tick_o[0], 1'b0);
        end

        note("u0 start while done");
        pulse_start(0);
        chk("t5_start_in_done", {run_o[0], done_o[0]}, 2'b01);
        note("u0 load in done");
        ld[0] = 1'b1;
        cyc(1);
        ld[0] = 1'b0;
        chk("t5_load_done", done_o[0], 1'b0);
        chk("t5_load_digits", dgx[0], 16'h0012);

        note("u0 start then speed 3");
        pulse_start(0);
        spd[0] = 2'd3;
        cyc(7);
        chk("t2_still_12", dgx[0], 16'h0012);
        cyc(1);
        chk("t2_first_11", dgx[0], 16'h0011);
        cyc(1);
        chk("t2_fast_10", dgx[0], 16'h0010);
        cyc(1);
        chk("t2_fast_09", dgx[0], 16'h0009);
        chk("t2_fast_tick", tick_o[0], 1'b1);
        note("u0 load while running");
        ld[0] = 1'b1;
        cyc(1);
        ld[0] = 1'b0;
        spd[0] = 2'd0;
        chk("t2_load_tick", {tick_o[0], exp_o[0], run_o[0]}, 3'b000);
        chk("t2_load_digits", dgx[0], 16'h0012);

        note("u0 pause at prescaler 3");
        pulse_start(0);
        cyc(4);
        ps[0] = 1'b1;
        cyc(1);
        chk("t4_paused", run_o[0], 1'b0);
        cyc(19);
        ps[0] = 1'b0;
        chk("t4_frozen", dgx[0], 16'h0012);
        note("u0 resume");
        pulse_start(0);
        cyc(3);
        chk("t4_resume_wait", {run_o[0], tick_o[0]}, 2'b10);
        cyc(1);
        chk("t4_resume_tick", tick_o[0], 1'b1);
        chk("t4_resume_digits", dgx[0], 16'h0011);
        note("u0 pause+start together");
        ps[0] = 1'b1;
        sr[0] = 1'b1;
        cyc(1);
        ps[0] = 1'b0;
        sr[0] = 1'b0;
        chk("t4_ps_and_start", {run_o[0], done_o[0]}, 2'b00);
        cyc(3);
        chk("t4_ps_hold", dgx[0], 16'h0011);
        pulse_start(0);
        chk("t4_rerun", run_o[0], 1'b1);

        note("async reset mid-run");
        cyc(2);
        @(posedge ClockIn);
        #2 ResetN = 1'b0;
        #1;
        chk("t5_async_digits", dgx[0], 16'h0012);
        chk("t5_async_flags", {run_o[0], done_o[0], exp_o[0], tick_o[0]}, 4'b0000);
        @(negedge ClockIn);
        ResetN = 1'b1;
        cyc(1);

        note("u1 count up to 25");
        pulse_start(1);
        cyc(72);
        chk("t3_up_09", dgx[1], 16'h0009);
        cyc(8);
        chk("t3_up_carry_10", dgx[1], 16'h0010);
        cyc(120);
        chk("t3_up_25", dgx[1], 16'h0025);
        chk("t3_up_expired", {exp_o[1], done_o[1]}, 2'b11);
        cyc(1);
        chk("t3_up_after", {exp_o[1], done_o[1], dgx[1]}, {2'b01, 16'h0025});

        note("u2 zero start value");
        pulse_start(2);
        chk("t6_zero_done", {done_o[2], exp_o[2], tick_o[2], run_o[2]}, 4'b1100);
        cyc(1);
        chk("t6_zero_after", {done_o[2], exp_o[2], tick_o[2]}, 3'b100);

        note("u3 one digit, speed 3");
        spd[3] = 2'd3;
        pulse_start(3);
        chk("t6_u3_start", {run_o[3], dgx[3]}, {1'b1, 16'h0005});
        cyc(1);
        chk("t6_u3_4", dgx[3], 16'h0004);
`ifdef BCD_GAME_TIMER_WARNING_EN
        chk("t6_warn_low_4", warn_o[3], 1'b0);
`endif
        cyc(1);
        chk("t6_u3_3", dgx[3], 16'h0003);
`ifdef BCD_GAME_TIMER_WARNING_EN
        chk("t6_warn_rise_3", warn_o[3], 1'b1);
`endif
        cyc(3);
        chk("t6_u3_done", {dgx[3], done_o[3], exp_o[3]}, {16'h0000, 2'b11});
`ifdef BCD_GAME_TIMER_WARNING_EN
        chk("t6_warn_fall_done", warn_o[3], 1'b0);
`endif
        cyc(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
